// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branch/jump direction and target from the
// comparison result, flags mispredictions and misaligned targets, and
// drives a registered redirect followed by a multi-cycle flush strobe.
// Optional feature macro: BRANCH_RESOLVE_PERF_EN adds branch and
// mispredict counters (branch_count_o, mispredict_count_o).
module branch_resolve_unit #(
  parameter int dataWidth   = 32,
  parameter int flushCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           branch_op_i,
  input  logic [dataWidth-1:0] pc_i,
  input  logic [dataWidth-1:0] imm_i,
  input  logic [dataWidth-1:0] rs1_i,
  input  logic [dataWidth-1:0] compare_result_i,
  input  logic                 predicted_taken_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 redirect_valid_o,
  output logic [dataWidth-1:0] redirect_pc_o,
  output logic [dataWidth-1:0] link_value_o,
  output logic                 misalign_exc_o,
  output logic                 flush_o
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [dataWidth-1:0] branch_count_o,
  output logic [dataWidth-1:0] mispredict_count_o
`endif
);

  localparam int CntW = $clog2(flushCycles + 1);
  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_JAL    = 2'd2;
  localparam logic [1:0] OP_JALR   = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                out_valid_q;
  logic                flush_q;
  logic                redirect_valid_q;
  logic                misalign_q;
  logic [dataWidth-1:0] redirect_pc_q;
  logic [dataWidth-1:0] link_q;

  logic                redirect_valid_d;
  logic                misalign_d;
  logic [dataWidth-1:0] redirect_pc_d;
  logic [dataWidth-1:0] link_d;

  logic [dataWidth-1:0] target;
  logic [dataWidth-1:0] seq_pc;
  logic [dataWidth-1:0] jalr_sum;
  logic                 taken;
  logic                 redirect_raw;
  logic                 accept;
  logic                 xfer;

  // Only the condition bit of the comparison word carries information.
  logic unused_cmp_bits;
  assign unused_cmp_bits = ^compare_result_i[dataWidth-1:1];

  // A redirecting result blocks the same-cycle accept so the flush can start.
  assign in_ready_o = rst_n & ((state_q == IDLE) |
                               ((state_q == HOLD) & out_ready_i & ~redirect_valid_q));
  assign accept     = in_valid_i & in_ready_o;
  assign xfer       = out_valid_q & out_ready_i;

  // Resolve direction, target and redirect decision for the incoming op.
  always_comb begin
    seq_pc           = pc_i + dataWidth'(4);
    jalr_sum         = rs1_i + imm_i;
    target           = pc_i + imm_i;
    taken            = 1'b0;
    redirect_raw     = 1'b0;
    case (branch_op_i)
      OP_BRANCH: begin
        taken        = compare_result_i[0];
        redirect_raw = compare_result_i[0] != predicted_taken_i;
      end
      OP_JAL: begin
        taken        = 1'b1;
        redirect_raw = ~predicted_taken_i;
      end
      OP_JALR: begin
        target       = jalr_sum & ~dataWidth'(1);
        taken        = 1'b1;
        redirect_raw = 1'b1;
      end
      default: begin
        taken        = 1'b0;
        redirect_raw = 1'b0;
      end
    endcase
    misalign_d       = taken & (target[1:0] != 2'b00);
    redirect_valid_d = redirect_raw & ~misalign_d;
    redirect_pc_d    = taken ? target : seq_pc;
    link_d           = ((branch_op_i == OP_JAL) || (branch_op_i == OP_JALR)) ? seq_pc : '0;
  end

  // Control FSM with registered result and flush outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      out_valid_q      <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      misalign_q       <= 1'b0;
      redirect_pc_q    <= '0;
      link_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q          <= HOLD;
            out_valid_q      <= 1'b1;
            redirect_valid_q <= redirect_valid_d;
            misalign_q       <= misalign_d;
            redirect_pc_q    <= redirect_pc_d;
            link_q           <= link_d;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            if (redirect_valid_q) begin
              state_q          <= FLUSH;
              cnt_q            <= CntW'(flushCycles);
              flush_q          <= 1'b1;
              out_valid_q      <= 1'b0;
              redirect_valid_q <= 1'b0;
            end else if (accept) begin
              redirect_valid_q <= redirect_valid_d;
              misalign_q       <= misalign_d;
              redirect_pc_q    <= redirect_pc_d;
              link_q           <= link_d;
            end else begin
              state_q          <= IDLE;
              out_valid_q      <= 1'b0;
              misalign_q       <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          flush_q     <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o      = out_valid_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign misalign_exc_o   = misalign_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign link_value_o     = link_q;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic                 is_branch_q;
  logic [dataWidth-1:0] branch_cnt_q;
  logic [dataWidth-1:0] mispredict_cnt_q;

  // Count consumed results; the held op type travels with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_branch_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (accept) begin
        is_branch_q <= (branch_op_i != OP_NONE);
      end
      if (xfer) begin
        branch_cnt_q     <= branch_cnt_q + dataWidth'(is_branch_q);
        mispredict_cnt_q <= mispredict_cnt_q + dataWidth'(redirect_valid_q);
      end
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: scoreboard of expected results pushed
// on accept and compared on each output transfer, plus scenario tasks.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  branch_op_i;
  logic [31:0] pc_i, imm_i, rs1_i, compare_result_i;
  logic        predicted_taken_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] link_value_o;
  logic        misalign_exc_o;
  logic        flush_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(.dataWidth(32), .flushCycles(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .branch_op_i       (branch_op_i),
    .pc_i              (pc_i),
    .imm_i             (imm_i),
    .rs1_i             (rs1_i),
    .compare_result_i  (compare_result_i),
    .predicted_taken_i (predicted_taken_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .link_value_o      (link_value_o),
    .misalign_exc_o    (misalign_exc_o),
    .flush_o           (flush_o)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] link;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference behaviour of one resolved instruction.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] rs1,
                                 input logic [31:0] cmp, input logic pred);
    exp_t        e;
    logic [31:0] tgt;
    logic        tk;
    tgt = 32'h0;
    tk  = 1'b0;
    case (op)
      2'd1: begin tgt = pc + imm; tk = cmp[0]; end
      2'd2: begin tgt = pc + imm; tk = 1'b1; end
      2'd3: begin tgt = (rs1 + imm) & 32'hFFFF_FFFE; tk = 1'b1; end
      default: begin tgt = 32'h0; tk = 1'b0; end
    endcase
    e.mis  = tk && (tgt[1:0] != 2'b00);
    e.rpc  = tk ? tgt : pc + 32'd4;
    e.link = (op == 2'd2 || op == 2'd3) ? pc + 32'd4 : 32'h0;
    if (e.mis) e.rv = 1'b0;
    else if (op == 2'd1 || op == 2'd2) e.rv = (tk != pred);
    else if (op == 2'd3) e.rv = 1'b1;
    else e.rv = 1'b0;
    return e;
  endfunction

  // Scoreboard: compare on transfer, then record any accept this cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid_o && out_ready_i) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: transfer with rpc=%h but nothing expected", redirect_pc_o);
        end else begin
          mon_e = sb.pop_front();
          if ({redirect_valid_o, redirect_pc_o, link_value_o, misalign_exc_o} !==
              {mon_e.rv, mon_e.rpc, mon_e.link, mon_e.mis}) begin
            miscompares++;
            $display("FAIL xfer: got rv=%b rpc=%h link=%h mis=%b, expected rv=%b rpc=%h link=%h mis=%b",
                     redirect_valid_o, redirect_pc_o, link_value_o, misalign_exc_o,
                     mon_e.rv, mon_e.rpc, mon_e.link, mon_e.mis);
          end else begin
            $display("xfer ok: rv=%b rpc=%h link=%h mis=%b",
                     redirect_valid_o, redirect_pc_o, link_value_o, misalign_exc_o);
          end
        end
      end
      if (in_valid_i && in_ready_o)
        sb.push_back(model(branch_op_i, pc_i, imm_i, rs1_i, compare_result_i, predicted_taken_i));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] cmp, input logic pred);
    in_valid_i        = 1'b1;
    branch_op_i       = op;
    pc_i              = pc;
    imm_i             = imm;
    rs1_i             = rs1;
    compare_result_i  = cmp;
    predicted_taken_i = pred;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_i = 1'b0; branch_op_i = 2'd0; pc_i = '0; imm_i = '0; rs1_i = '0;
    compare_result_i = '0; predicted_taken_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({out_valid_o, flush_o, redirect_valid_o, misalign_exc_o, redirect_pc_o, link_value_o, in_ready_o} !== 71'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got ov=%b fl=%b rv=%b mis=%b rpc=%h link=%h rdy=%b, expected all 0",
                 out_valid_o, flush_o, redirect_valid_o, misalign_exc_o, redirect_pc_o, link_value_o, in_ready_o);
      end
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b expected 1 after reset", in_ready_o);
    end
  endtask

  task automatic test_mispredict();
    int flush_cnt;
    cyc();
    out_ready_i = 1'b1;
    drive(2'd1, 32'h100, 32'h20, 32'h0, 32'h1, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid_o, redirect_valid_o, redirect_pc_o} !== {1'b1, 1'b1, 32'h120}) begin
      miscompares++;
      $display("FAIL mispredict_out: got ov=%b rv=%b rpc=%h, expected 1 1 00000120",
               out_valid_o, redirect_valid_o, redirect_pc_o);
    end
    flush_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (flush_o) begin
        flush_cnt++;
        vectors++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_ready: in_ready=%b out_valid=%b during flush, expected 0 0", in_ready_o, out_valid_o);
        end
      end
    end
    vectors++;
    if (flush_cnt != 2) begin
      miscompares++;
      $display("FAIL flush_len: flush high %0d cycles, expected 2", flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(2'd1, 32'h200 + 32'(k * 16), 32'h40, 32'h0, 32'h0, 1'b0);
      else in_valid_i = 1'b0;
      @(negedge clk);
      if (k >= 1) begin
        vectors++;
        if (out_valid_o !== 1'b1 || flush_o !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_valid: cycle %0d out_valid=%b flush=%b, expected 1 0", k, out_valid_o, flush_o);
        end
      end
      if (k < 4) begin
        vectors++;
        if (in_ready_o !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready: cycle %0d in_ready=%b, expected 1", k, in_ready_o);
        end
      end
      cyc();
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid_o);
    end
  endtask

  task automatic test_jalr_misalign();
    cyc();
    out_ready_i = 1'b1;
    drive(2'd3, 32'h40, 32'h4, 32'h1003, 32'h0, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid_o, redirect_pc_o, link_value_o, misalign_exc_o, redirect_valid_o} !==
        {1'b1, 32'h1006, 32'h44, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL jalr_misalign: got ov=%b rpc=%h link=%h mis=%b rv=%b, expected 1 00001006 00000044 1 0",
               out_valid_o, redirect_pc_o, link_value_o, misalign_exc_o, redirect_valid_o);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (flush_o !== 1'b0 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL jalr_noflush: flush=%b out_valid=%b, expected 0 0", flush_o, out_valid_o);
    end
  endtask

  task automatic test_jal_wrap();
    cyc();
    out_ready_i = 1'b1;
    drive(2'd2, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b1);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid_o, redirect_pc_o, link_value_o, redirect_valid_o, misalign_exc_o} !==
        {1'b1, 32'h4, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL jal_wrap: got ov=%b rpc=%h link=%h rv=%b mis=%b, expected 1 00000004 00000000 0 0",
               out_valid_o, redirect_pc_o, link_value_o, redirect_valid_o, misalign_exc_o);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_pc;
    logic [31:0] snap_link;
    logic        snap_rv;
    cyc();
    out_ready_i = 1'b0;
    drive(2'd1, 32'h300, 32'h10, 32'h0, 32'h1, 1'b1);
    cyc();
    drive(2'd1, 32'h400, 32'h8, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    snap_pc = redirect_pc_o; snap_link = link_value_o; snap_rv = redirect_valid_o;
    vectors++;
    if ({out_valid_o, in_ready_o, redirect_pc_o} !== {1'b1, 1'b0, 32'h310}) begin
      miscompares++;
      $display("FAIL bp_first: got ov=%b rdy=%b rpc=%h, expected 1 0 00000310", out_valid_o, in_ready_o, redirect_pc_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid_o, in_ready_o, redirect_pc_o, link_value_o, redirect_valid_o} !==
          {1'b1, 1'b0, snap_pc, snap_link, snap_rv}) begin
        miscompares++;
        $display("FAIL bp_stable: got ov=%b rdy=%b rpc=%h link=%h rv=%b, expected 1 0 %h %h %b",
                 out_valid_o, in_ready_o, redirect_pc_o, link_value_o, redirect_valid_o, snap_pc, snap_link, snap_rv);
      end
    end
    cyc();
    out_ready_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: in_ready=%b expected 1", in_ready_o);
    end
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid_o, redirect_pc_o} !== {1'b1, 32'h404}) begin
      miscompares++;
      $display("FAIL bp_second: got ov=%b rpc=%h, expected 1 00000404", out_valid_o, redirect_pc_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid_flush();
    cyc();
    out_ready_i = 1'b1;
    drive(2'd1, 32'h100, 32'h20, 32'h0, 32'h1, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    vectors++;
    if (flush_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: flush=%b in second flush cycle, expected 1", flush_o);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({flush_o, out_valid_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_flush: flush=%b out_valid=%b right after reset, expected 0 0", flush_o, out_valid_o);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_residual: flush=%b after reset, expected 0", flush_o);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_sb: %0d results pending, expected 0", sb.size());
    end
    cyc();
    drive(2'd1, 32'h500, 32'h0C, 32'h0, 32'h1, 1'b1);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid_o, redirect_pc_o, redirect_valid_o} !== {1'b1, 32'h50C, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_after: got ov=%b rpc=%h rv=%b, expected 1 0000050c 0",
               out_valid_o, redirect_pc_o, redirect_valid_o);
    end
    cyc();
  endtask

  task automatic test_random();
    int wait_cnt;
    cyc();
    for (int i = 0; i < 80; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        drive(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 64)),
              $urandom, 32'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        in_valid_i = 1'b0;
      cyc();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    wait_cnt = 0;
    while ((sb.size() != 0 || out_valid_o || flush_o) && wait_cnt < 20) begin
      cyc();
      wait_cnt++;
    end
    vectors++;
    if (sb.size() != 0 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: %0d pending, out_valid=%b, expected 0 0", sb.size(), out_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_back_to_back();
    test_jalr_misalign();
    test_jal_wrap();
    test_backpressure();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits directly downstream of the comparison unit. Consumes its 32-bit result word (bit 0 = condition true) together with the branch/jump context.
- Resolves the actual direction and target, detects mispredictions, and emits a registered redirect plus a multi-cycle pipeline flush to fetch/decode.
- Single-entry registered stage with valid/ready on both sides.

Parameters:
- dataWidth, 32, datapath and PC width.
- flushCycles, 2, number of cycles flush stays high after a redirecting result is consumed (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- inValid  input  1  upstream has a branch/jump to resolve.
- inReady  output  1  stage can accept this cycle.
- branchOp  input  2  0=NONE, 1=BRANCH, 2=JAL, 3=JALR.
- pc  input  dataWidth  PC of the instruction.
- imm  input  dataWidth  sign-extended offset.
- rs1  input  dataWidth  base register value (JALR only).
- compareResult  input  dataWidth  comparison unit output; only bit 0 used.
- predictedTaken  input  1  fetch-stage prediction.
- outValid  output  1  registered result valid.
- outReady  input  1  downstream accepts the result.
- redirectValid  output  1  result requires fetch redirect.
- redirectPC  output  dataWidth  corrected next PC.
- linkValue  output  dataWidth  pc+4 for JAL/JALR, else 0.
- misalignExc  output  1  taken target not 4-byte aligned.
- flush  output  1  pipeline flush strobe.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, flush counter 0.
- FSM states:
  - IDLE: output register empty.
  - HOLD: outValid=1, waiting for outReady.
  - FLUSH: flush=1, counting.
- inReady = (state==IDLE) or (state==HOLD and outReady). inReady is 0 in FLUSH.
- Accept when inValid and inReady. Result is registered; appears on outputs the next cycle (latency 1). Next state is HOLD.
- Arithmetic (all wraps modulo 2^dataWidth):
  - target = pc+imm for BRANCH/JAL.
  - target = (rs1+imm) with bit 0 cleared for JALR.
  - seqPC = pc+4.
- taken:
  - BRANCH: compareResult[0].
  - JAL/JALR: 1.
  - NONE: 0.
- misalignExc = taken and target[1:0]!=0. When set, redirectValid=0.
- redirectValid (when misalignExc=0):
  - BRANCH/JAL: taken != predictedTaken.
  - JALR: always 1.
  - NONE: never.
- redirectPC = taken ? target : seqPC.
- NONE passes through: outValid=1, all flags 0, redirectPC=seqPC.
- HOLD exits:
  - Transfer (outValid and outReady) with redirectValid=1: go to FLUSH, load counter with flushCycles, clear outValid. Same-cycle input is not accepted (inReady=0).
  - Transfer without redirect: concurrent accept allowed (back-to-back, full throughput); otherwise go to IDLE.
  - No transfer: outputs must stay stable while outValid and !outReady.
- FLUSH: flush=1 each cycle. Counter decrements; at 1 go to IDLE. flush is high for exactly flushCycles cycles.
- Reset asserted mid-HOLD or mid-FLUSH: immediate return to the reset state, no residual flush.

Optional Feature:
- Macro BRANCH_RESOLVE_PERF_EN.
- Defined: adds two dataWidth output counters.
  - branchCount: +1 per consumed result with branchOp!=NONE.
  - mispredictCount: +1 per consumed result with redirectValid=1.
  - Both wrap at 2^dataWidth and reset to 0.
- Undefined: ports and logic are absent. Core behaviour is identical.

Test Plan:
- BRANCH, pc=0x100, imm=0x20, compareResult=1, predictedTaken=0, outReady=1 → next cycle outValid=1, redirectValid=1, redirectPC=0x120; then flush=1 for exactly 2 cycles with inReady=0.
- BRANCH, compareResult=0, predictedTaken=0, pc=0x200 → redirectValid=0, redirectPC=0x204, no flush. Repeated each cycle with outReady=1 → one result per cycle.
- JALR, rs1=0x1003, imm=0x4, pc=0x40 → redirectPC=0x1006, linkValue=0x44, misalignExc=1, redirectValid=0.
- JAL, pc=0xFFFFFFFC, imm=0x8, predictedTaken=1 → redirectPC=0x4 (wrap), linkValue=0x0, redirectValid=0.
- outReady held 0 for 3 cycles after accept → outputs stable, inReady=0; on release, a new input is accepted in the same cycle.
- reset deasserted-low during the second flush cycle → flush=0 and outValid=0 immediately; the next accept behaves normally.
